vend_controller: RTL and testbench

VEND_CONTROLLER -- requirements
Module: vend_controller

---
 rtl/vend_pkg.sv | 41 ++++
 rtl/vend_timer.sv | 30 +++
 rtl/vend_controller.sv | 161 ++++++++++++++++
 tb/tb_vend_controller.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: FSM states, coin values and money arithmetic.
package vend_pkg;

    localparam int MONEY_W = 8;
    localparam int GOODS_W = 4;

    typedef logic [MONEY_W-1:0] money_t;
    typedef logic [GOODS_W-1:0] goods_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        PAY      = 3'd2,
        DISPENSE = 3'd3,
        CHANGE   = 3'd4
    } state_t;

    localparam money_t COIN_VAL_1  = 8'd1;
    localparam money_t COIN_VAL_5  = 8'd5;
    localparam money_t COIN_VAL_10 = 8'd10;
    localparam money_t COIN_VAL_20 = 8'd20;

    function automatic money_t coin_value(input logic [1:0] code);
        money_t val;
        case (code)
            2'b00:   val = COIN_VAL_1;
            2'b01:   val = COIN_VAL_5;
            2'b10:   val = COIN_VAL_10;
            default: val = COIN_VAL_20;
        endcase
        return val;
    endfunction

    // Credit never wraps; it pins at the all-ones value.
    function automatic money_t sat_add(input money_t a, input money_t b);
        logic [MONEY_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[MONEY_W] ? {MONEY_W{1'b1}} : sum[MONEY_W-1:0];
    endfunction

endpackage

// File: rtl/vend_timer.sv
// Purpose: idle-cycle counter for the payment window; expire flags TIMEOUT_CYC-1 reached.
// Latency: reload takes effect on the next edge; expire is decoded from the count register.
// Backpressure: none; counter sticks at its last value until reloaded.
module vend_timer #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (reload) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (count == LAST);

endmodule

// File: rtl/vend_controller.sv
// Purpose: vending FSM - selection lookup, coin credit, vend, change/refund and timeout refund.
// Latency: all outputs registered; events appear one clk after the deciding input cycle.
// Backpressure: none; coins outside PAY are bounced with coin_reject, stray sel/cancel ignored.
module vend_controller
    import vend_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sel_valid,
    input  logic [GOODS_W-1:0]  sel_goods,
    output logic [GOODS_W-1:0]  goods,
    input  logic [MONEY_W-1:0]  goods_price,
    input  logic [3:0]          goods_num,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic                cancel,
    output logic [MONEY_W-1:0]  paid,
    output logic                dispense,
    output logic [GOODS_W-1:0]  dispense_goods,
    output logic [MONEY_W-1:0]  change,
    output logic                change_valid,
    output logic                sold_out,
    output logic                coin_reject,
    output logic [2:0]          state
);

    state_t state_q, state_d;
    money_t price_q, price_d;
    money_t paid_d, change_d;
    goods_t goods_d, dispense_goods_d;
    logic   dispense_d, change_valid_d, sold_out_d, coin_reject_d;

    money_t paid_coin;
    logic   price_met, stock_ok, refund_req;
    logic   timer_reload, timer_expire;

    // Credit including a coin arriving this cycle; only meaningful in PAY.
    assign paid_coin    = coin_valid ? sat_add(paid, coin_value(coin_type)) : paid;
    assign price_met    = (paid_coin >= price_q);
    assign stock_ok     = (goods_num != 4'd0) && (goods_price != '0);
    assign timer_reload = (state_q != PAY) || coin_valid;
    assign refund_req   = cancel || (timer_expire && !coin_valid);

    vend_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .reload (timer_reload),
        .expire (timer_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (sel_valid) state_d = LOOKUP;
            LOOKUP:   state_d = stock_ok ? PAY : IDLE;
            PAY: begin
                if (price_met) begin
                    state_d = DISPENSE;
                end else if (refund_req) begin
                    state_d = CHANGE;
                end
            end
            DISPENSE: state_d = CHANGE;
            CHANGE:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        goods_d          = goods;
        paid_d           = paid;
        price_d          = price_q;
        change_d         = change;
        dispense_goods_d = dispense_goods;
        dispense_d       = 1'b0;
        change_valid_d   = 1'b0;
        sold_out_d       = 1'b0;
        coin_reject_d    = 1'b0;
        case (state_q)
            IDLE: begin
                coin_reject_d = coin_valid;
                if (sel_valid) goods_d = sel_goods;
            end
            LOOKUP: begin
                coin_reject_d = coin_valid;
                if (stock_ok) begin
                    price_d = goods_price;
                end else begin
                    sold_out_d = 1'b1;
                    goods_d    = '0;
                end
            end
            PAY: begin
                paid_d = paid_coin;
                // A coin that meets the price wins over a same-cycle cancel.
                if (price_met) begin
                    dispense_d       = 1'b1;
                    dispense_goods_d = goods;
                end else if (refund_req) begin
                    change_d       = paid_coin;
                    change_valid_d = 1'b1;
                end
            end
            DISPENSE: begin
                coin_reject_d  = coin_valid;
                change_d       = paid - price_q;
                change_valid_d = 1'b1;
            end
            CHANGE: begin
                coin_reject_d = coin_valid;
                paid_d        = '0;
                goods_d       = '0;
                price_d       = '0;
            end
            default: begin
                paid_d  = '0;
                goods_d = '0;
                price_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            goods          <= '0;
            paid           <= '0;
            price_q        <= '0;
            change         <= '0;
            dispense_goods <= '0;
            dispense       <= 1'b0;
            change_valid   <= 1'b0;
            sold_out       <= 1'b0;
            coin_reject    <= 1'b0;
        end else begin
            goods          <= goods_d;
            paid           <= paid_d;
            price_q        <= price_d;
            change         <= change_d;
            dispense_goods <= dispense_goods_d;
            dispense       <= dispense_d;
            change_valid   <= change_valid_d;
            sold_out       <= sold_out_d;
            coin_reject    <= coin_reject_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: stimulus pushes expected pulse events, a negedge monitor pops and compares.
module tb_vend_controller;
    import vend_pkg::*;

    localparam int T_CYC = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sel_valid = 1'b0;
    logic [3:0] sel_goods = '0;
    logic [3:0] goods;
    logic [7:0] goods_price = '0;
    logic [3:0] goods_num = '0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_type = '0;
    logic       cancel = 1'b0;
    logic [7:0] paid;
    logic       dispense;
    logic [3:0] dispense_goods;
    logic [7:0] change;
    logic       change_valid;
    logic       sold_out;
    logic       coin_reject;
    logic [2:0] state;

    always #5 clk = ~clk;

    vend_controller #(.TIMEOUT_CYC(T_CYC)) dut (
        .clk            (clk),
        .rst            (rst),
        .sel_valid      (sel_valid),
        .sel_goods      (sel_goods),
        .goods          (goods),
        .goods_price    (goods_price),
        .goods_num      (goods_num),
        .coin_valid     (coin_valid),
        .coin_type      (coin_type),
        .cancel         (cancel),
        .paid           (paid),
        .dispense       (dispense),
        .dispense_goods (dispense_goods),
        .change         (change),
        .change_valid   (change_valid),
        .sold_out       (sold_out),
        .coin_reject    (coin_reject),
        .state          (state)
    );

    typedef enum int {EV_DISP, EV_CHG, EV_SOLD, EV_REJ} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [31:0] val;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic expect_ev(input ev_kind_t k, input logic [31:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic see_ev(input ev_kind_t k, input logic [31:0] v);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got %s value %0d, required no event", k.name(), v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || v !== e.val) begin
                failures++;
                $display("FAIL event_order: got %s value %0d, required %s value %0d",
                         k.name(), v, e.kind.name(), e.val);
            end
        end
    endtask

    // Monitor: samples pulses mid-cycle, fixed order when several fire together.
    always @(negedge clk) begin
        if (dispense)     see_ev(EV_DISP, 32'(dispense_goods));
        if (change_valid) see_ev(EV_CHG, 32'(change));
        if (sold_out)     see_ev(EV_SOLD, 32'(goods));
        if (coin_reject)  see_ev(EV_REJ, 32'(paid));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic select(input logic [3:0] g, input logic [7:0] price, input logic [3:0] num);
        goods_price = price;
        goods_num   = num;
        sel_valid   = 1'b1;
        sel_goods   = g;
        cyc();
        sel_valid   = 1'b0;
        sel_goods   = '0;
    endtask

    task automatic coin(input logic [1:0] t);
        coin_valid = 1'b1;
        coin_type  = t;
        cyc();
        coin_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, 32'(state), 0);
        chk({tag, "_goods"}, 32'(goods), 0);
        chk({tag, "_paid"}, 32'(paid), 0);
        chk({tag, "_change"}, 32'(change), 0);
        chk({tag, "_disp_goods"}, 32'(dispense_goods), 0);
        chk({tag, "_pulses"}, 32'({dispense, change_valid, sold_out, coin_reject}), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench still running at time %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, including a select attempted while held in reset.
        sel_valid = 1'b1;
        sel_goods = 4'd9;
        cyc();
        sel_valid = 1'b0;
        cyc();
        chk_all_zero("reset");
        rst = 1'b1;

        // Exact pay: 10 + 5 against price 15.
        select(4'd1, 8'd15, 4'd3);
        chk("exact_lookup_state", 32'(state), 1);
        chk("exact_goods", 32'(goods), 1);
        cyc();
        chk("exact_pay_state", 32'(state), 2);
        coin(2'b10);
        chk("exact_paid10", 32'(paid), 10);
        expect_ev(EV_DISP, 1);
        expect_ev(EV_CHG, 0);
        coin(2'b01);
        chk("exact_disp_state", 32'(state), 3);
        cyc();
        chk("exact_change_state", 32'(state), 4);
        cyc();
        chk("exact_idle_state", 32'(state), 0);
        chk("exact_paid_clr", 32'(paid), 0);
        chk("exact_goods_clr", 32'(goods), 0);

        // Overpay: 20 against price 12 leaves 8.
        select(4'd2, 8'd12, 4'd1);
        cyc();
        expect_ev(EV_DISP, 2);
        expect_ev(EV_CHG, 8);
        coin(2'b11);
        chk("over_paid20", 32'(paid), 20);
        cyc();
        chk("over_change8", 32'(change), 8);
        cyc();
        cyc();
        chk("over_change_hold", 32'(change), 8);

        // Sold out, then a coin in IDLE is bounced.
        expect_ev(EV_SOLD, 0);
        select(4'd3, 8'd7, 4'd0);
        chk("sold_lookup_state", 32'(state), 1);
        cyc();
        chk("sold_idle_state", 32'(state), 0);
        chk("sold_goods_clr", 32'(goods), 0);
        cyc();
        chk("sold_no_pay", 32'(state), 0);
        expect_ev(EV_REJ, 0);
        coin(2'b00);
        chk("idle_coin_paid", 32'(paid), 0);
        cancel = 1'b1;
        cyc();
        cancel = 1'b0;
        chk("idle_cancel_ignored", 32'(state), 0);

        // Cancel with same-cycle coin: 10 + 5 refunded, price 30 not met.
        select(4'd4, 8'd30, 4'd1);
        cyc();
        coin(2'b10);
        expect_ev(EV_CHG, 15);
        coin_valid = 1'b1;
        coin_type  = 2'b01;
        cancel     = 1'b1;
        cyc();
        coin_valid = 1'b0;
        cancel     = 1'b0;
        chk("cancel_state", 32'(state), 4);
        chk("cancel_paid", 32'(paid), 15);
        cyc();
        chk("cancel_idle", 32'(state), 0);

        // Timeout: 5 paid, then silence; still in PAY after 7 idle cycles, refund on the 8th.
        select(4'd5, 8'd50, 4'd2);
        cyc();
        coin(2'b01);
        repeat (T_CYC - 1) cyc();
        chk("timeout_not_yet", 32'(state), 2);
        expect_ev(EV_CHG, 5);
        cyc();
        chk("timeout_change_state", 32'(state), 4);
        chk("timeout_change5", 32'(change), 5);
        cyc();

        // Reset mid-PAY discards credit silently.
        select(4'd6, 8'd50, 4'd2);
        cyc();
        coin(2'b10);
        chk("rst_pre_paid", 32'(paid), 10);
        rst = 1'b0;
        #2;
        chk_all_zero("midrst");
        cyc();
        cyc();
        rst = 1'b1;

        // Saturation: 13 x 20 pins at 255 against price 255; coin during DISPENSE bounced.
        select(4'd7, 8'd255, 4'd1);
        chk("post_rst_first_edge", 32'(state), 1);
        cyc();
        repeat (12) coin(2'b11);
        chk("sat_paid240", 32'(paid), 240);
        chk("sat_still_pay", 32'(state), 2);
        expect_ev(EV_DISP, 7);
        expect_ev(EV_CHG, 0);
        expect_ev(EV_REJ, 255);
        coin(2'b11);
        chk("sat_paid255", 32'(paid), 255);
        chk("sat_disp_state", 32'(state), 3);
        coin(2'b11);
        chk("sat_reject_paid", 32'(paid), 255);
        chk("sat_change_state", 32'(state), 4);
        cyc();
        chk("sat_idle", 32'(state), 0);

        repeat (3) cyc();
        chk("events_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
